// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-I Harvard CPU slice.
//   - RESET_VECTOR_DEFAULT: boot address used when the top is not overridden.
//   - OP_* / FN_*: primary opcode and SPECIAL funct encodings of the subset.
//   - alu_op_t and alu_eval(): the integer datapath operations.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  // Shifts operate on b (the rt / immediate operand) by sh, as MIPS does.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'h0000_0000, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'h0000_0000, a < b};
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $signed(b) >>> sh;
      ALU_LUI:  r = {b[15:0], 16'h0000};
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_harvard_cpu_if.sv
// mips_harvard_cpu_if: Harvard bus between the CPU (master) and its memories (slave).
//   instr_address  -> PC;                instr_readdata <- ROM word (combinational)
//   data_address   -> load/store address; data_writedata -> store data
//   data_write     -> store strobe;       data_read      -> load strobe
//   data_readdata  <- RAM word (combinational)
interface mips_harvard_cpu_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output instr_address, data_address, data_write, data_read, data_writedata,
    input  instr_readdata, data_readdata
  );

  modport slave (
    input  instr_address, data_address, data_write, data_read, data_writedata,
    output instr_readdata, data_readdata
  );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit GPR file.
//   clk, reset         : clock and synchronous active-high clear of all registers
//   we, waddr, wdata   : write port, applied at the rising edge; $0 writes dropped
//   raddr_a/b, rdata_a/b : combinational read ports; $0 always reads zero
//   v0                 : live tap of $2
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] v0
);

  logic [31:0] regs [32];

  // Register array: clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0000_0000;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'h0000_0000 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0000_0000 : regs[raddr_b];
  assign v0      = regs[2];

endmodule

// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu: single-cycle MIPS-I integer subset with branch delay slots.
//   clk, reset    : clock; synchronous active-high reset (dominates clock_enable)
//   clock_enable  : 0 freezes PC, GPRs and active, and suppresses stores
//   active        : 1 while running, 0 once the PC has reached address 0
//   register_v0   : live contents of GPR $2
//   bus (master)  : instruction fetch and data load/store ports
// The delay slot is modelled with a second PC register (npc): each executed
// instruction moves npc into pc and computes the address after that.
module mips_harvard_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clock_enable,
  output logic               active,
  output logic [31:0]        register_v0,
  mips_harvard_cpu_if.master bus
);

  logic [31:0] pc, npc, npc_next, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, shift_amt, dest;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val, alu_b, alu_result, wb_data;
  logic [31:0] pc_plus4, branch_target, jump_target;
  logic        run, reg_write, wb_link, is_load, is_store, rf_we;
  alu_op_t     alu_op;

  assign instr    = bus.instr_readdata;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  assign run           = clock_enable & active;
  assign pc_plus4      = pc + 32'd4;
  // Branch and jump targets are relative to the delay-slot address.
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Control decode and next-npc selection; unknown encodings fall through as NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_b     = rt_val;
    shift_amt = shamt;
    reg_write = 1'b0;
    dest      = rd;
    wb_link   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    npc_next  = npc + 32'd4;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL:  begin alu_op = ALU_SLL; reg_write = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; reg_write = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; reg_write = 1'b1; end
          FN_SLLV: begin alu_op = ALU_SLL; shift_amt = rs_val[4:0]; reg_write = 1'b1; end
          FN_SRLV: begin alu_op = ALU_SRL; shift_amt = rs_val[4:0]; reg_write = 1'b1; end
          FN_SRAV: begin alu_op = ALU_SRA; shift_amt = rs_val[4:0]; reg_write = 1'b1; end
          FN_JR:   npc_next = rs_val;
          FN_JALR: begin npc_next = rs_val; reg_write = 1'b1; wb_link = 1'b1; end
          FN_ADDU: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
          FN_SUBU: begin alu_op = ALU_SUB;  reg_write = 1'b1; end
          FN_AND:  begin alu_op = ALU_AND;  reg_write = 1'b1; end
          FN_OR:   begin alu_op = ALU_OR;   reg_write = 1'b1; end
          FN_XOR:  begin alu_op = ALU_XOR;  reg_write = 1'b1; end
          FN_NOR:  begin alu_op = ALU_NOR;  reg_write = 1'b1; end
          FN_SLT:  begin alu_op = ALU_SLT;  reg_write = 1'b1; end
          FN_SLTU: begin alu_op = ALU_SLTU; reg_write = 1'b1; end
          default: reg_write = 1'b0;
        endcase
      end
      OP_J:    npc_next = jump_target;
      OP_JAL:  begin npc_next = jump_target; reg_write = 1'b1; dest = 5'd31; wb_link = 1'b1; end
      OP_BEQ:  npc_next = (rs_val == rt_val) ? branch_target : npc + 32'd4;
      OP_BNE:  npc_next = (rs_val != rt_val) ? branch_target : npc + 32'd4;
      OP_BLEZ: npc_next = (rs_val[31] || (rs_val == 32'h0)) ? branch_target : npc + 32'd4;
      OP_BGTZ: npc_next = (!rs_val[31] && (rs_val != 32'h0)) ? branch_target : npc + 32'd4;
      OP_ADDIU: begin alu_b = imm_sext; dest = rt; reg_write = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = imm_sext; dest = rt; reg_write = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = imm_sext; dest = rt; reg_write = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_b = imm_zext; dest = rt; reg_write = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_b = imm_zext; dest = rt; reg_write = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_b = imm_zext; dest = rt; reg_write = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI;  alu_b = imm_zext; dest = rt; reg_write = 1'b1; end
      OP_LW:    begin alu_b = imm_sext; dest = rt; reg_write = 1'b1; is_load = 1'b1; end
      OP_SW:    begin alu_b = imm_sext; is_store = 1'b1; end
      default:  reg_write = 1'b0;
    endcase
  end

  assign alu_result = alu_eval(alu_op, rs_val, alu_b, shift_amt);

  // Write-back source: link address, load data or ALU result.
  always_comb begin
    wb_data = alu_result;
    if (wb_link) begin
      wb_data = pc + 32'd8;
    end else if (is_load) begin
      wb_data = bus.data_readdata;
    end else begin
      wb_data = alu_result;
    end
  end

  assign rf_we = run & reg_write;

  mips_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (dest),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .v0      (register_v0)
  );

  assign bus.instr_address  = pc;
  assign bus.data_address   = alu_result;
  assign bus.data_writedata = rt_val;
  assign bus.data_write     = run & is_store;
  assign bus.data_read      = active & is_load;

  // PC pair and run flag; the run stops on the edge that loads PC with 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_VECTOR;
      npc    <= RESET_VECTOR + 32'd4;
      active <= 1'b1;
    end else if (run) begin
      pc     <= npc;
      npc    <= npc_next;
      active <= (npc != 32'h0000_0000);
    end
  end

endmodule

// File: tb/tb_mips_harvard_cpu.sv
module tb_mips_harvard_cpu;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clock_enable = 1'b0;
  logic        active;
  logic [31:0] register_v0;

  mips_harvard_cpu_if bus ();

  mips_harvard_cpu #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .reset        (reset),
    .clock_enable (clock_enable),
    .active       (active),
    .register_v0  (register_v0),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Memories owned by the bench: ROM at the reset vector, 64-word RAM at 0.
  logic [31:0] rom [0:63];
  logic [31:0] ram [0:63];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RV;
    if (off < 32'd256) return rom[off[7:2]];
    return 32'h0;
  endfunction

  assign bus.instr_readdata = rom_word(bus.instr_address);
  assign bus.data_readdata  = ram[bus.data_address[7:2]];
  always @(posedge clk) if (bus.data_write === 1'b1) ram[bus.data_address[7:2]] <= bus.data_writedata;

  // Instruction-level reference model.
  logic [31:0] m_pc, m_npc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [0:63];
  bit          m_active;

  int checks = 0;
  int errors = 0;
  logic [31:0] o_pc, o_v0, o_da, o_wd;
  logic        o_dw, o_dr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(input int op, input logic [25:0] idx);
    return {6'(op), idx};
  endfunction

  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, dpc, nn, val;
    int          wr;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];
    a = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]}; ze = {16'h0, ins[15:0]};
    dpc = m_pc + 32'd4; nn = m_npc + 32'd4; wr = 0; val = 32'h0;
    case (op)
      6'h00: case (fn)
        6'h00: begin wr = rd; val = b << sh; end
        6'h02: begin wr = rd; val = b >> sh; end
        6'h03: begin wr = rd; val = $signed(b) >>> sh; end
        6'h04: begin wr = rd; val = b << a[4:0]; end
        6'h06: begin wr = rd; val = b >> a[4:0]; end
        6'h07: begin wr = rd; val = $signed(b) >>> a[4:0]; end
        6'h08: nn = a;
        6'h09: begin nn = a; wr = rd; val = m_pc + 32'd8; end
        6'h21: begin wr = rd; val = a + b; end
        6'h23: begin wr = rd; val = a - b; end
        6'h24: begin wr = rd; val = a & b; end
        6'h25: begin wr = rd; val = a | b; end
        6'h26: begin wr = rd; val = a ^ b; end
        6'h27: begin wr = rd; val = ~(a | b); end
        6'h2A: begin wr = rd; val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'h2B: begin wr = rd; val = (a < b) ? 32'd1 : 32'd0; end
        default: ;
      endcase
      6'h02: nn = {dpc[31:28], ins[25:0], 2'b00};
      6'h03: begin nn = {dpc[31:28], ins[25:0], 2'b00}; wr = 31; val = m_pc + 32'd8; end
      6'h04: if (a == b) nn = dpc + (se << 2);
      6'h05: if (a != b) nn = dpc + (se << 2);
      6'h06: if ($signed(a) <= 32'sd0) nn = dpc + (se << 2);
      6'h07: if ($signed(a) > 32'sd0) nn = dpc + (se << 2);
      6'h09: begin wr = rt; val = a + se; end
      6'h0A: begin wr = rt; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = rt; val = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = rt; val = a & ze; end
      6'h0D: begin wr = rt; val = a | ze; end
      6'h0E: begin wr = rt; val = a ^ ze; end
      6'h0F: begin wr = rt; val = {ins[15:0], 16'h0}; end
      6'h23: begin wr = rt; val = m_mem[((a + se) >> 2) & 32'd63]; end
      6'h2B: m_mem[((a + se) >> 2) & 32'd63] = b;
      default: ;
    endcase
    if (wr != 0) m_regs[wr] = val;
    m_pc = m_npc;
    m_npc = nn;
    if (m_pc == 32'h0) m_active = 0;
  endtask

  // One clock: compare outputs at the falling edge, advance the model, take the edge.
  task automatic cycle(input logic ce);
    logic [31:0] ins, ea;
    bit exp_sw, exp_lw;
    clock_enable = ce;
    @(negedge clk);
    o_pc = bus.instr_address; o_v0 = register_v0; o_da = bus.data_address;
    o_wd = bus.data_writedata; o_dw = bus.data_write; o_dr = bus.data_read;
    ins = rom_word(m_pc);
    ea = m_regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
    exp_sw = m_active && ce && (ins[31:26] == 6'h2B);
    exp_lw = m_active && (ins[31:26] == 6'h23);
    check("pc", o_pc, m_pc);
    check("v0", o_v0, m_regs[2]);
    check("active", 32'(active), 32'(m_active));
    check("data_write", 32'(o_dw), 32'(exp_sw));
    check("data_read", 32'(o_dr), 32'(exp_lw));
    if (exp_sw) begin
      check("st_addr", o_da, ea);
      check("st_data", o_wd, m_regs[ins[20:16]]);
    end
    if (exp_lw) check("ld_addr", o_da, ea);
    if (ce && m_active) model_step(ins);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clock_enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clock_enable = 1'b1;
    m_pc = RV; m_npc = RV + 32'd4; m_active = 1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    #1;
    check("rst_pc", bus.instr_address, 32'hBFC0_0000);
    check("rst_v0", register_v0, 32'h0);
    check("rst_active", 32'(active), 32'd1);
    check("rst_dw", 32'(bus.data_write), 32'd0);
  endtask

  task automatic run_to_halt(input bit rand_ce);
    int n;
    n = 0;
    while (m_active && n < 400) begin
      cycle(rand_ce ? ($urandom_range(0, 4) != 0) : 1'b1);
      n++;
    end
    check("halt_timeout", 32'(m_active), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
  endtask

  function automatic int rreg();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 2;
      2: return 8;
      3: return 9;
      4: return 10;
      default: return 11;
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] tgt, halted_v0;
    int k;
    int fns [8] = '{'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int sfn [6] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07};
    int iop [6] = '{'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E};
    bit prev_br;

    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      m_mem[i] = ram[i];
    end

    // Countdown: v0 seen at the BNE is 5..0; the final delay slot leaves -1.
    clear_rom();
    rom[0] = i_ins('h09, 0, 2, 5);
    rom[1] = i_ins('h05, 2, 0, -1);
    rom[2] = i_ins('h09, 2, 2, -1);
    rom[3] = r_ins(0, 0, 0, 0, 'h08);
    rom[4] = 32'h0;
    do_reset();
    cycle(1'b1);
    for (int it = 0; it < 6; it++) begin
      cycle(1'b1);
      check("cd_bne_pc", o_pc, RV + 32'd4);
      check("cd_v0", o_v0, 32'(5 - it));
      if (it == 2) begin
        for (int s = 0; s < 3; s++) begin
          cycle(1'b0);
          check("ce_pc", o_pc, RV + 32'd8);
          check("ce_v0", o_v0, 32'd3);
        end
      end
      cycle(1'b1);
    end
    run_to_halt(1'b0);
    check("cd_halt_pc", o_pc, 32'h0);
    check("cd_halt_v0", o_v0, 32'hFFFF_FFFF);

    // Memory round trip, store held off by clock_enable for three cycles.
    clear_rom();
    rom[0] = i_ins('h0F, 0, 8, 'h1234);
    rom[1] = i_ins('h0D, 8, 8, 'h5678);
    rom[2] = i_ins('h2B, 0, 8, 4);
    rom[3] = i_ins('h23, 0, 2, 4);
    rom[4] = 32'h0;
    rom[5] = r_ins(0, 0, 0, 0, 'h08);
    do_reset();
    cycle(1'b1);
    cycle(1'b1);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0);
      check("sw_gated", 32'(o_dw), 32'd0);
    end
    cycle(1'b1);
    check("sw_write", 32'(o_dw), 32'd1);
    check("sw_addr", o_da, 32'd4);
    check("sw_data", o_wd, 32'h1234_5678);
    cycle(1'b1);
    check("lw_read", 32'(o_dr), 32'd1);
    check("lw_addr", o_da, 32'd4);
    cycle(1'b1);
    check("lw_v0", o_v0, 32'h1234_5678);
    run_to_halt(1'b0);

    // JAL with delay slot, then JALR to 0 linking into $9.
    clear_rom();
    tgt = RV + 32'd16;
    rom[0] = j_ins('h03, tgt[27:2]);
    rom[1] = i_ins('h09, 0, 2, 7);
    rom[4] = r_ins(31, 0, 2, 0, 'h21);
    rom[5] = r_ins(0, 0, 9, 0, 'h09);
    rom[6] = r_ins(9, 0, 2, 0, 'h21);
    do_reset();
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    check("jal_target", o_pc, RV + 32'd16);
    check("jal_slot_v0", o_v0, 32'd7);
    cycle(1'b1);
    check("jal_link", o_v0, RV + 32'd8);
    run_to_halt(1'b0);
    check("jalr_link", o_v0, RV + 32'd28);

    // $0 stays zero.
    clear_rom();
    rom[0] = i_ins('h09, 0, 2, 3);
    rom[1] = i_ins('h09, 0, 0, 9);
    rom[2] = r_ins(0, 0, 2, 0, 'h21);
    rom[3] = r_ins(0, 0, 0, 0, 'h08);
    do_reset();
    cycle(1'b1);
    cycle(1'b1);
    check("z_v0_set", o_v0, 32'd3);
    cycle(1'b1);
    cycle(1'b1);
    check("z_v0", o_v0, 32'd0);
    run_to_halt(1'b0);

    // Random straight-line programs with short forward branches.
    for (int p = 0; p < 4; p++) begin
      clear_rom();
      prev_br = 0;
      rom[0] = i_ins('h09, 0, 2, $urandom_range(0, 65535));
      for (int i = 1; i < 24; i++) begin
        k = $urandom_range(0, 11);
        if (k == 7 && (prev_br || i >= 20)) k = 0;
        prev_br = (k == 7);
        case (k)
          0: rom[i] = r_ins(rreg(), rreg(), rreg(), 0, fns[$urandom_range(0, 7)]);
          1, 2: rom[i] = r_ins(rreg(), rreg(), rreg(), $urandom_range(0, 31), sfn[$urandom_range(0, 5)]);
          3: rom[i] = i_ins(iop[$urandom_range(0, 5)], rreg(), rreg(), $urandom_range(0, 65535));
          4: rom[i] = i_ins('h0F, 0, rreg(), $urandom_range(0, 65535));
          5: rom[i] = i_ins('h2B, 0, rreg(), 4 * $urandom_range(0, 63));
          6: rom[i] = i_ins('h23, 0, rreg(), 4 * $urandom_range(0, 63));
          7: rom[i] = i_ins(4 + $urandom_range(0, 3), rreg(), rreg(), $urandom_range(1, 2));
          8: rom[i] = ($urandom_range(0, 1) == 1) ? r_ins(rreg(), rreg(), 2, 0, 'h3F)
                                                  : i_ins('h3F, rreg(), 2, $urandom_range(0, 65535));
          default: rom[i] = i_ins('h09, rreg(), 2, $urandom_range(0, 65535));
        endcase
      end
      rom[24] = r_ins(0, 0, 0, 0, 'h08);
      do_reset();
      if (p == 0) begin
        for (int c = 0; c < 9; c++) cycle(1'b1);
        do_reset();
      end
      run_to_halt(1'b1);
      halted_v0 = m_regs[2];
      cycle(1'b1);
      check("rand_halt_v0", o_v0, halted_v0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
